vproc_mul_sched: RTL

//  Shares one vproc_mul_block between two requesters: lane A (index 0) and lane B (index 1).

---
 rtl/vproc_mul_sched_pkg.sv | 40 ++++
 rtl/vproc_mul_sched_if.sv | 32 +++
 rtl/vproc_mul_block.sv | 64 ++++++
 rtl/vproc_mul_res_fifo.sv | 70 +++++++
 rtl/vproc_mul_sched.sv | 125 ++++++++++++
 5 files changed

// File: rtl/vproc_mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mul_sched_pkg
// Description : Shared types for the two-lane multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package vproc_mul_sched_pkg;

    typedef enum logic [0:0] {
        MUL_GENERIC = 1'b0
    } mul_type_e;

    typedef struct packed {
        logic [16:0] op1;
        logic [16:0] op2;
        logic [15:0] acc;
        logic        acc_flag;
        logic        acc_sub;
    } mul_req_t;

    typedef struct packed {
        logic valid;
        logic id;
    } mul_tag_t;

    // Accumulator controls travel separately because the multiplier wants
    // them one operand-stage later than op1/op2.
    typedef struct packed {
        logic [15:0] acc;
        logic        acc_flag;
        logic        acc_sub;
    } mul_acc_t;

    typedef struct packed {
        logic        id;
        logic [32:0] res;
    } mul_res_t;

endpackage
`default_nettype wire

// File: rtl/vproc_mul_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mul_sched_if
// Description : Request/result handshake bundle of the multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface vproc_mul_sched_if;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][16:0] req_op1_i;
    logic [1:0][16:0] req_op2_i;
    logic [1:0][15:0] req_acc_i;
    logic [1:0]       req_acc_flag_i;
    logic [1:0]       req_acc_sub_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [32:0]      res_data_o;
    logic             res_id_o;

    modport slave (
        input  req_valid_i, req_op1_i, req_op2_i, req_acc_i,
               req_acc_flag_i, req_acc_sub_i, res_ready_i,
        output req_ready_o, res_valid_o, res_data_o, res_id_o
    );

    modport master (
        output req_valid_i, req_op1_i, req_op2_i, req_acc_i,
               req_acc_flag_i, req_acc_sub_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_data_o, res_id_o
    );
endinterface
`default_nettype wire

// File: rtl/vproc_mul_block.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mul_block
// Description : Non-stallable signed 17x17 multiply-accumulate, 0..3 stages.
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_mul_block
    import vproc_mul_sched_pkg::*;
#(
    parameter mul_type_e   MUL_TYPE = MUL_GENERIC,
    parameter int unsigned BUF_OPS  = 1,
    parameter int unsigned BUF_MUL  = 1,
    parameter int unsigned BUF_RES  = 1
) (
    input  wire logic        clk_i,
    input  wire logic [16:0] op1_i,
    input  wire logic [16:0] op2_i,
    input  wire mul_acc_t    acc_i,
    output logic      [32:0] res_o
);
    logic [16:0] op1_s, op2_s;
    logic [32:0] prod_c, prod_m;
    mul_acc_t    acc_m;
    logic [32:0] acc_ext, res_c;

    if (BUF_OPS != 0) begin : g_buf_ops
        logic [33:0] ops_q, ops_d;
        always_comb ops_d = {op1_i, op2_i};
        always_ff @(posedge clk_i) ops_q <= ops_d;
        assign {op1_s, op2_s} = ops_q;
    end else begin : g_no_buf_ops
        assign {op1_s, op2_s} = {op1_i, op2_i};
    end

    // Low 33 bits of a sign-extended product equal the signed product mod 2^33.
    if (MUL_TYPE == MUL_GENERIC) begin : g_mul_generic
        assign prod_c = {{16{op1_s[16]}}, op1_s} * {{16{op2_s[16]}}, op2_s};
    end

    if (BUF_MUL != 0) begin : g_buf_mul
        logic [51:0] mul_q, mul_d;
        always_comb mul_d = {prod_c, acc_i};
        always_ff @(posedge clk_i) mul_q <= mul_d;
        assign {prod_m, acc_m} = mul_q;
    end else begin : g_no_buf_mul
        assign prod_m = prod_c;
        assign acc_m  = acc_i;
    end

    always_comb begin
        acc_ext = acc_m.acc_flag ? {{17{acc_m.acc[15]}}, acc_m.acc} : 33'd0;
        res_c   = acc_m.acc_sub ? (acc_ext - prod_m) : (acc_ext + prod_m);
    end

    if (BUF_RES != 0) begin : g_buf_res
        logic [32:0] res_q, res_d;
        always_comb res_d = res_c;
        always_ff @(posedge clk_i) res_q <= res_d;
        assign res_o = res_q;
    end else begin : g_no_buf_res
        assign res_o = res_c;
    end
endmodule
`default_nettype wire

// File: rtl/vproc_mul_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mul_res_fifo
// Description : Synchronous result FIFO of {id,res} with a registered count.
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_mul_res_fifo
    import vproc_mul_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             push_i,
    input  wire mul_res_t         data_i,
    input  wire logic             pop_i,
    output logic                  valid_o,
    output mul_res_t              data_o,
    output logic      [CNT_W-1:0] count_o
);
    mul_res_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            mem_d[wr_q] = data_i;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop_i) rd_d = ptr_inc(rd_q);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) mem_q <= mem_d;

    // Empty FIFO drives zeros so the outputs look reset without clearing storage.
    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && (cnt_q == CNT_W'(DEPTH))));
endmodule
`default_nettype wire

// File: rtl/vproc_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mul_sched
// Description : Round-robin two-lane scheduler for one shared multiplier,
//               with credit-guarded result buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_mul_sched
    import vproc_mul_sched_pkg::*;
#(
    parameter mul_type_e   MUL_TYPE       = MUL_GENERIC,
    parameter int unsigned BUF_OPS        = 1,
    parameter int unsigned BUF_MUL        = 1,
    parameter int unsigned BUF_RES        = 1,
    parameter int unsigned RES_FIFO_DEPTH = 4
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    vproc_mul_sched_if.slave bus
);
    localparam int unsigned LAT   = BUF_OPS + BUF_MUL + BUF_RES;
    localparam int unsigned CNT_W = $clog2(RES_FIFO_DEPTH + 1);

    logic             rr_q, rr_d;
    logic [1:0]       grant;
    logic             issue, issue_id;
    logic [31:0]      used;
    logic [1:0]       inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_valid;
    mul_req_t         req_sel;
    mul_acc_t         acc_issue, acc_mul;
    mul_tag_t         issue_tag, tag_out;
    mul_res_t         fifo_out;
    logic [32:0]      mul_res;

    // Every op still in the pipe owns a FIFO slot; a same-cycle pop frees
    // its slot only once the registered count drops.
    always_comb begin
        used  = 32'(fifo_count) + 32'(inflight);
        grant = 2'b00;
        if (!rst_i && (used < 32'(RES_FIFO_DEPTH))) begin
            if (&bus.req_valid_i) grant[rr_q] = 1'b1;
            else                  grant       = bus.req_valid_i;
        end
        issue    = |grant;
        issue_id = grant[1];
        rr_d     = issue ? ~issue_id : rr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end

    always_comb begin
        req_sel.op1      = bus.req_op1_i[issue_id];
        req_sel.op2      = bus.req_op2_i[issue_id];
        req_sel.acc      = bus.req_acc_i[issue_id];
        req_sel.acc_flag = bus.req_acc_flag_i[issue_id];
        req_sel.acc_sub  = bus.req_acc_sub_i[issue_id];
        acc_issue        = '{acc: req_sel.acc, acc_flag: req_sel.acc_flag,
                             acc_sub: req_sel.acc_sub};
        issue_tag        = '{valid: issue, id: issue_id};
    end

    if (BUF_OPS == 0) begin : g_acc_direct
        assign acc_mul = acc_issue;
    end else begin : g_acc_delay
        mul_acc_t acc_q, acc_d;
        always_comb acc_d = acc_issue;
        always_ff @(posedge clk_i) acc_q <= acc_d;
        assign acc_mul = acc_q;
    end

    if (LAT == 0) begin : g_tag_lat0
        assign tag_out  = issue_tag;
        assign inflight = 2'd0;
    end else begin : g_tag_pipe
        mul_tag_t [LAT-1:0] tag_q, tag_d;
        always_comb begin
            tag_d[0] = issue_tag;
            for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
            inflight = 2'd0;
            for (int i = 0; i < LAT; i++) inflight = inflight + {1'b0, tag_q[i].valid};
        end
        always_ff @(posedge clk_i) begin
            if (rst_i) tag_q <= '0;
            else       tag_q <= tag_d;
        end
        assign tag_out = tag_q[LAT-1];
    end

    vproc_mul_block #(
        .MUL_TYPE (MUL_TYPE),
        .BUF_OPS  (BUF_OPS),
        .BUF_MUL  (BUF_MUL),
        .BUF_RES  (BUF_RES)
    ) u_mul (
        .clk_i (clk_i),
        .op1_i (req_sel.op1),
        .op2_i (req_sel.op2),
        .acc_i (acc_mul),
        .res_o (mul_res)
    );

    vproc_mul_res_fifo #(
        .DEPTH (RES_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tag_out.valid),
        .data_i  ('{id: tag_out.id, res: mul_res}),
        .pop_i   (fifo_valid & bus.res_ready_i),
        .valid_o (fifo_valid),
        .data_o  (fifo_out),
        .count_o (fifo_count)
    );

    assign bus.req_ready_o = grant;
    assign bus.res_valid_o = fifo_valid;
    assign bus.res_data_o  = fifo_out.res;
    assign bus.res_id_o    = fifo_out.id;
endmodule
`default_nettype wire
